// File: rtl/mac_accumulator34.sv
// Signed 16x16 multiply-accumulate producing a 34-bit dot product of LEN pairs.
// Define MAC_SAT_EN to make the accumulation saturate instead of wrapping.
module mac_accumulator34 #(
    parameter int unsigned LEN = 4
) (
    input  logic               C,
    input  logic               Rn,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [15:0] A,
    input  logic signed [15:0] B,
    output logic        [33:0] D,
    output logic               out_valid,
    input  logic               out_ready
);

    typedef enum logic {
        ST_ACC,
        ST_HOLD
    } state_t;

    localparam logic [7:0] LEN_C = 8'(LEN);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [33:0] acc_q, acc_d;
    logic [33:0] prod_q, prod_d;
    logic [33:0] d_q, d_d;
    logic        p_valid_q, p_valid_d;

    logic               accept;
    logic signed [31:0] mult;
    logic        [33:0] sum;

    assign mult = A * B;

`ifdef MAC_SAT_EN
    logic [34:0] sum_wide;
    assign sum_wide = {acc_q[33], acc_q} + {prod_q[33], prod_q};
    // A carry into the extra sign bit that disagrees with bit 33 marks overflow.
    always_comb begin
        if (sum_wide[34] != sum_wide[33]) begin
            sum = sum_wide[34] ? 34'h2_0000_0000 : 34'h1_FFFF_FFFF;
        end else begin
            sum = sum_wide[33:0];
        end
    end
`else
    assign sum = acc_q + prod_q;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        prod_d    = prod_q;
        d_d       = d_q;
        p_valid_d = 1'b0;

        in_ready  = (state_q == ST_ACC) && (cnt_q != LEN_C);
        out_valid = (state_q == ST_HOLD);
        accept    = in_valid && in_ready;

        if (accept) begin
            prod_d    = {{2{mult[31]}}, mult};
            p_valid_d = 1'b1;
            cnt_d     = cnt_q + 8'd1;
        end

        // cnt == LEN with a product in flight means this edge adds the last term.
        if (p_valid_q) begin
            if (cnt_q == LEN_C) begin
                d_d     = sum;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = ST_HOLD;
            end else begin
                acc_d = sum;
            end
        end

        if ((state_q == ST_HOLD) && out_ready) begin
            state_d = ST_ACC;
        end
    end

    always_ff @(posedge C) begin
        if (!Rn) begin
            state_q   <= ST_ACC;
            cnt_q     <= '0;
            acc_q     <= '0;
            prod_q    <= '0;
            d_q       <= '0;
            p_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            prod_q    <= prod_d;
            d_q       <= d_d;
            p_valid_q <= p_valid_d;
        end
    end

    assign D = d_q;

endmodule

// File: tb/tb_mac_accumulator34.sv
// Bench for mac_accumulator34: LEN=4 and LEN=8 instances, directed table plus
// randomized sets checked against a sum-of-products model (honours MAC_SAT_EN).
module tb_mac_accumulator34;

    logic C = 1'b0;
    always #5 C = ~C;

    logic        rn   [2];
    logic        iv   [2];
    logic        ordy [2];
    logic        irdy [2];
    logic        ov   [2];
    logic [15:0] a    [2];
    logic [15:0] b    [2];
    logic [33:0] d    [2];

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    mac_accumulator34 #(.LEN(4)) dut4 (
        .C(C), .Rn(rn[0]), .in_valid(iv[0]), .in_ready(irdy[0]), .A(a[0]), .B(b[0]),
        .D(d[0]), .out_valid(ov[0]), .out_ready(ordy[0])
    );

    mac_accumulator34 #(.LEN(8)) dut8 (
        .C(C), .Rn(rn[1]), .in_valid(iv[1]), .in_ready(irdy[1]), .A(a[1]), .B(b[1]),
        .D(d[1]), .out_valid(ov[1]), .out_ready(ordy[1])
    );

    typedef struct {
        logic [15:0] a [4];
        logic [15:0] b [4];
        logic [33:0] exp;
        string       nm;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge C);
        #1;
    endtask

    // Offer one pair to instance k; it must be accepted at the coming edge.
    task automatic feed(input int k, input logic [15:0] av, input logic [15:0] bv);
        iv[k] = 1'b1;
        a[k]  = av;
        b[k]  = bv;
        chk("in_ready_before_accept", 64'(irdy[k]), 64'd1);
        tick();
        iv[k] = 1'b0;
        a[k]  = 16'($urandom);
        b[k]  = 16'($urandom);
    endtask

    task automatic gap(input int k);
        iv[k] = 1'b0;
        a[k]  = 16'($urandom);
        b[k]  = 16'($urandom);
        tick();
    endtask

    // Called right after the final accept edge: drain, hold, handshake.
    task automatic finish_set(input int k, input logic [33:0] exp, input string nm);
        chk({nm, "_drain_ov"}, 64'(ov[k]), 64'd0);
        chk({nm, "_drain_rdy"}, 64'(irdy[k]), 64'd0);
        tick();
        chk({nm, "_ov"}, 64'(ov[k]), 64'd1);
        chk({nm, "_D"}, 64'(d[k]), 64'(exp));
        chk({nm, "_hold_rdy"}, 64'(irdy[k]), 64'd0);
        ordy[k] = 1'b1;
        tick();
        ordy[k] = 1'b0;
        chk({nm, "_release_ov"}, 64'(ov[k]), 64'd0);
        chk({nm, "_release_rdy"}, 64'(irdy[k]), 64'd1);
    endtask

    function automatic logic [33:0] ref_sum(input longint p[$]);
        longint acc;
        longint lim;
        lim = longint'(1) <<< 33;
        acc = 0;
        foreach (p[i]) begin
            acc = acc + p[i];
`ifdef MAC_SAT_EN
            if (acc > lim - 1) acc = lim - 1;
            else if (acc < -lim) acc = -lim;
`else
            acc = acc & ((longint'(1) <<< 34) - 1);
            if (acc >= lim) acc = acc - (longint'(1) <<< 34);
`endif
        end
        return acc[33:0];
    endfunction

    function automatic logic [15:0] rand_op();
        case ($urandom_range(0, 3))
            0:       return 16'h8000;
            1:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [33:0] ovf_exp;
        for (int k = 0; k < 2; k++) begin
            rn[k] = 1'b0; iv[k] = 1'b0; ordy[k] = 1'b0; a[k] = '0; b[k] = '0;
        end

        tbl[0].a = '{16'h0001, 16'h0002, 16'hFFFC, 16'h0064};
        tbl[0].b = '{16'h0001, 16'h0003, 16'h0005, 16'hFFFE};
        tbl[0].exp = 34'h3_FFFF_FF2B; tbl[0].nm = "basic";
        tbl[1].a = '{16'h0007, 16'h0007, 16'h0007, 16'h0007};
        tbl[1].b = '{16'h0007, 16'h0007, 16'h0007, 16'h0007};
        tbl[1].exp = 34'h0_0000_00C4; tbl[1].nm = "sevens";
        tbl[2].a = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
        tbl[2].b = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
        tbl[2].exp = 34'h1_0000_0000; tbl[2].nm = "minmin";
        tbl[3].a = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        tbl[3].b = '{16'h0001, 16'h0001, 16'h0001, 16'h0001};
        tbl[3].exp = 34'h3_FFFF_FFFC; tbl[3].nm = "neg_small";
        tbl[4].a = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        tbl[4].b = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
        tbl[4].exp = 34'h3_0002_0000; tbl[4].nm = "maxmin";

        // Reset with random inputs on both instances.
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < 2; k++) begin
                iv[k] = 1'($urandom); ordy[k] = 1'($urandom);
                a[k] = 16'($urandom); b[k] = 16'($urandom);
            end
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            rn[k] = 1'b1; iv[k] = 1'b0; ordy[k] = 1'b0;
            chk("reset_D", 64'(d[k]), 64'd0);
            chk("reset_ov", 64'(ov[k]), 64'd0);
            chk("reset_rdy", 64'(irdy[k]), 64'd1);
        end

        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 4; j++) feed(0, tbl[i].a[j], tbl[i].b[j]);
            finish_set(0, tbl[i].exp, tbl[i].nm);
        end

        // Backpressure: five cycles of HOLD with noise on the inputs.
        for (int j = 0; j < 4; j++) feed(0, 16'd3, 16'd4);
        tick();
        chk("bp_ov", 64'(ov[0]), 64'd1);
        for (int c = 0; c < 5; c++) begin
            iv[0] = 1'($urandom); a[0] = 16'($urandom); b[0] = 16'($urandom);
            tick();
            chk("bp_D", 64'(d[0]), 64'd48);
            chk("bp_ov_hold", 64'(ov[0]), 64'd1);
            chk("bp_rdy", 64'(irdy[0]), 64'd0);
        end
        iv[0] = 1'b0; ordy[0] = 1'b1;
        tick();
        ordy[0] = 1'b0;
        chk("bp_release_ov", 64'(ov[0]), 64'd0);
        chk("bp_release_rdy", 64'(irdy[0]), 64'd1);
        chk("bp_release_D", 64'(d[0]), 64'd48);

        // Gaps: in_valid pattern 1,0,0,1,1,0,1.
        feed(0, 16'd7, 16'd7); chk("gap_ov", 64'(ov[0]), 64'd0);
        gap(0);                chk("gap_ov", 64'(ov[0]), 64'd0);
        gap(0);                chk("gap_ov", 64'(ov[0]), 64'd0);
        feed(0, 16'd7, 16'd7); chk("gap_ov", 64'(ov[0]), 64'd0);
        feed(0, 16'd7, 16'd7); chk("gap_ov", 64'(ov[0]), 64'd0);
        gap(0);                chk("gap_ov", 64'(ov[0]), 64'd0);
        feed(0, 16'd7, 16'd7);
        finish_set(0, 34'd196, "gaps");

        // Overflow on the LEN=8 instance.
`ifdef MAC_SAT_EN
        ovf_exp = 34'h1_FFFF_FFFF;
`else
        ovf_exp = 34'h2_0000_0000;
`endif
        for (int j = 0; j < 8; j++) feed(1, 16'h8000, 16'h8000);
        finish_set(1, ovf_exp, "overflow");

        // Mid-set reset discards partial sum and the in-flight product.
        feed(0, 16'd5, 16'd5);
        feed(0, 16'd5, 16'd5);
        rn[0] = 1'b0;
        tick();
        rn[0] = 1'b1;
        chk("midrst_D", 64'(d[0]), 64'd0);
        chk("midrst_rdy", 64'(irdy[0]), 64'd1);
        for (int j = 0; j < 4; j++) feed(0, 16'd1, 16'd2);
        finish_set(0, 34'd8, "midrst");

        // Reset in HOLD drops the pending result.
        for (int j = 0; j < 4; j++) feed(0, 16'd2, 16'd2);
        tick();
        chk("holdrst_pre_ov", 64'(ov[0]), 64'd1);
        rn[0] = 1'b0;
        tick();
        rn[0] = 1'b1;
        chk("holdrst_ov", 64'(ov[0]), 64'd0);
        chk("holdrst_D", 64'(d[0]), 64'd0);
        chk("holdrst_rdy", 64'(irdy[0]), 64'd1);

        // Randomized sets against the sum-of-products model.
        for (int k = 0; k < 2; k++) begin
            int len;
            len = (k == 0) ? 4 : 8;
            for (int s = 0; s < 20; s++) begin
                longint prods[$];
                int     guard;
                int     w;
                logic   took;
                prods.delete();
                guard = 0;
                while (prods.size() < len && guard < 200) begin
                    iv[k]   = ($urandom_range(0, 3) != 0);
                    a[k]    = rand_op();
                    b[k]    = rand_op();
                    ordy[k] = 1'($urandom);
                    chk("rand_rdy", 64'(irdy[k]), 64'd1);
                    took = iv[k];
                    tick();
                    if (took)
                        prods.push_back(longint'($signed(a[k])) * longint'($signed(b[k])));
                    guard++;
                end
                iv[k] = 1'b0; ordy[k] = 1'b0;
                w = 0;
                while (!ov[k] && w < 4) begin
                    tick();
                    w++;
                end
                chk("rand_ov", 64'(ov[k]), 64'd1);
                chk("rand_D", 64'(d[k]), 64'(ref_sum(prods)));
                repeat ($urandom_range(0, 3)) tick();
                chk("rand_D_hold", 64'(d[k]), 64'(ref_sum(prods)));
                ordy[k] = 1'b1;
                tick();
                ordy[k] = 1'b0;
                chk("rand_release_ov", 64'(ov[k]), 64'd0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mac_accumulator34.md
# mac_accumulator34

Signed multiply-accumulate stage that feeds the 34-bit result register of the TPU processing element. It accepts a stream of 16-bit signed operand pairs over a valid/ready handshake and multiplies each pair. It sums LEN products into a 34-bit two's-complement dot product, then presents that result on D for the downstream 34-bit flip-flop bank to capture. It is the upstream neighbour of that register: its D output connects bit-for-bit to the register's D input, on the same clock C.

## Interface
- LEN, default 4: products per result; legal range 1..255; internal count register is 8 bits.
- C  input  1  clock; all state changes on the rising edge.
- Rn  input  1  synchronous active-low reset, sampled on the rising edge of C.
- in_valid  input  1  operand pair A/B is valid.
- in_ready  output  1  block accepts a pair this cycle.
- A  input  16  signed multiplicand.
- B  input  16  signed multiplier.
- D  output  34  signed dot-product result; drives the downstream 34-bit register.
- out_valid  output  1  D holds a completed result.
- out_ready  input  1  consumer has taken D.

## Operation
- Accept condition: in_valid && in_ready at a rising edge.
- Stage 1: on accept, the product register loads the 32-bit signed A*B, sign-extended to 34 bits, and p_valid is set. p_valid clears on any edge without an accept.
- Stage 2: when p_valid is set, acc <= acc + prod, using 34-bit arithmetic.
- cnt counts accepted pairs in the current set, from 0 to LEN.
- States:
  - ACC: in_ready = (cnt != LEN).
  - HOLD: in_ready = 0, out_valid = 1.
- ACC->HOLD: on the edge where the LEN-th product is added. D loads acc+prod, acc clears to 0, and cnt clears to 0.
- HOLD->ACC: on the edge where out_ready = 1. out_valid drops; D keeps its last value.
- in_ready is combinational from state and cnt only. It never depends on in_valid.
- A and B are ignored when there is no accept. Gaps in in_valid are allowed anywhere within a set.
- Reset (Rn=0 at an edge) sets state=ACC, cnt=0, acc=0, prod=0, p_valid=0, D=0, out_valid=0. Reset overrides every other event in the same cycle.
- Reset mid-set discards the partial sum and any in-flight product. Reset in HOLD drops the pending result.

## Timing
- Output values out of reset: D=0, out_valid=0, in_ready=1.
- Latency: final pair accepted at edge E. Product registered at E. Sum lands in D at E+1. out_valid is high in the cycle after E+1.
- Minimum period per result is LEN+2 edges: LEN accepts, 1 drain edge, and 1 handshake edge in HOLD.
- The first accept of the next set can occur at the edge after the HOLD handshake.
- D and out_valid are stable throughout HOLD regardless of A, B, or in_valid.
- out_ready is ignored outside HOLD.
- During drain, after cnt reaches LEN, in_ready = 0 even though state = ACC.

## Configuration
- MAC_SAT_EN undefined: stage 2 wraps modulo 2^34.
- MAC_SAT_EN defined: every stage-2 addition saturates.
  - Positive overflow clamps to 34'h1_FFFF_FFFF (2^33-1).
  - Negative overflow clamps to 34'h2_0000_0000 (-2^33).
  - Later additions in the same set start from the clamped value.
- Overflow is only possible when LEN >= 8.
- Handshake and timing are identical in both builds.

## Test plan
- Reset: hold Rn=0 for 3 edges with random inputs -> D=0, out_valid=0, in_ready=1 after the reset edges.
- Basic, LEN=4: pairs (1,1), (2,3), (-4,5), (100,-2) on consecutive cycles -> out_valid high 2 cycles after the last accept, D=34'h3_FFFF_FF2B (-213).
- Backpressure: hold out_ready=0 for 5 cycles in HOLD -> D and out_valid stable, in_ready=0. Raise out_ready for 1 cycle -> out_valid=0 and in_ready=1 next cycle.
- Gaps: LEN=4 with in_valid toggling 1,0,0,1,1,0,1 and pairs (7,7) each -> D=196, out_valid only after the 4th accept.
- Overflow: LEN=8, eight pairs of (-32768,-32768):
  - Build without MAC_SAT_EN -> D=34'h2_0000_0000.
  - Build with MAC_SAT_EN -> D=34'h1_FFFF_FFFF.
- Mid-set reset: accept 2 of 4 pairs (5,5), assert Rn=0 for 1 edge, then send 4 pairs (1,2) -> D=8, no residue from the first partial sum.
